// File: rtl/cacheline_burst_adapter.sv
// Cacheline <-> 4-beat burst adapter: one cache fill or writeback becomes one low-beat-first burst.
// Optional watchdog enabled by defining CACHELINE_BURST_ADAPTER_TIMEOUT_EN.
module cacheline_burst_adapter #(
    parameter int s_line   = 256,
    parameter int s_burst  = 64,
    parameter int s_offset = 5,
    parameter int TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i,
    output logic               error_o
);
    localparam int BEATS = s_line / s_burst;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       addr_q, addr_d;
    logic [s_line-1:0] wline_q, wline_d;
    logic [s_line-1:0] rbuf_q, rbuf_d;
    logic [s_line-1:0] fill_q, fill_d;
    logic [s_line-1:0] rbuf_merged;
    logic              last_beat;

`ifdef CACHELINE_BURST_ADAPTER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           error_q, error_d;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = addr_q;
        wline_d     = wline_q;
        rbuf_d      = rbuf_q;
        fill_d      = fill_q;
        rbuf_merged = rbuf_q;
        rbuf_merged[count_q*s_burst +: s_burst] = burst_i;
        last_beat   = (count_q == CW'(BEATS - 1));

        case (state_q)
            IDLE: begin
                // Write wins a simultaneous request; the read is dropped and must be re-presented.
                if (write_i) begin
                    addr_d  = address_i;
                    wline_d = line_i;
                    count_d = '0;
                    state_d = WRITE;
                end else if (read_i) begin
                    addr_d  = address_i;
                    count_d = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    rbuf_d  = rbuf_merged;
                    count_d = count_q + 1'b1;
                    // line_o only changes when a whole line has arrived.
                    if (last_beat) begin
                        fill_d  = rbuf_merged;
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (resp_i) begin
                    count_d = count_q + 1'b1;
                    if (last_beat) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef CACHELINE_BURST_ADAPTER_TIMEOUT_EN
        wd_d    = '0;
        error_d = error_q;
        if (state_q == READ || state_q == WRITE) begin
            if (resp_i) begin
                wd_d = '0;
            end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                error_d = 1'b1;
                state_d = IDLE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rbuf_q  <= '0;
            fill_q  <= '0;
`ifdef CACHELINE_BURST_ADAPTER_TIMEOUT_EN
            wd_q    <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rbuf_q  <= rbuf_d;
            fill_q  <= fill_d;
`ifdef CACHELINE_BURST_ADAPTER_TIMEOUT_EN
            wd_q    <= wd_d;
            error_q <= error_d;
`endif
        end
    end

    assign read_o    = (state_q == READ);
    assign write_o   = (state_q == WRITE);
    assign resp_o    = (state_q == DONE);
    assign address_o = addr_q & ADDR_MASK;
    assign burst_o   = (state_q == WRITE) ? wline_q[count_q*s_burst +: s_burst] : '0;
    assign line_o    = fill_q;
`ifdef CACHELINE_BURST_ADAPTER_TIMEOUT_EN
    assign error_o   = error_q;
`else
    assign error_o   = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Bench for cacheline_burst_adapter: vector table, hand-written corner sequences, random transactions.
// Define CACHELINE_BURST_ADAPTER_TIMEOUT_EN to also exercise the watchdog (TIMEOUT=8 here).
module tb_cacheline_burst_adapter;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i, error_o;

  int checks = 0;
  int errors = 0;
  logic [255:0] last_fill;

  cacheline_burst_adapter #(.s_line(256), .s_burst(64), .s_offset(5), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i), .error_o(error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  // One cache transaction. Beats for a read come from 'line'; pat gives resp_i per cycle (LSB first),
  // pat_len == 0 means random stalls (never more than 3 in a row).
  task automatic run_txn(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] line, input logic [15:0] pat, input int pat_len,
                         input logic [31:0] exp_addr);
    logic [63:0] exp_q[$];
    int beats, cyc, run0;
    bit r;
    for (int i = 0; i < 4; i++) exp_q.push_back(line[i*64 +: 64]);
    read_i = rd;
    write_i = wr;
    address_i = addr;
    line_i = wr ? line : rand_line();
    step();
    beats = 0;
    cyc = 0;
    run0 = 0;
    while (beats < 4 && cyc < 64) begin
      check({tag, ".req"}, {write_o, read_o}, wr ? 2'b10 : 2'b01);
      check({tag, ".resp_low"}, resp_o, 1'b0);
      check({tag, ".addr"}, address_o, exp_addr);
      check({tag, ".line_hold"}, line_o, last_fill);
      if (wr) check({tag, ".burst_o"}, burst_o, exp_q[0]);
      if (pat_len > 0) r = (cyc < pat_len) ? pat[cyc] : 1'b1;
      else r = (run0 >= 3) ? 1'b1 : ($urandom_range(0, 99) >= 40);
      run0 = r ? 0 : run0 + 1;
      resp_i = r;
      burst_i = (!wr && r) ? exp_q[0] : {$urandom(), $urandom()};
      step();
      if (r) begin
        void'(exp_q.pop_front());
        beats++;
      end
      cyc++;
    end
    if (beats < 4) begin
      checks++;
      errors++;
      $display("FAIL %s.budget: got %0d beats expected 4", tag, beats);
    end
    resp_i = 1'b0;
    check({tag, ".done_resp"}, resp_o, 1'b1);
    check({tag, ".done_req"}, {write_o, read_o}, 2'b00);
    check({tag, ".done_err"}, error_o, 1'b0);
    if (!wr) last_fill = line;
    check({tag, ".line_o"}, line_o, last_fill);
    read_i = 1'b0;
    write_i = 1'b0;
    step();
    check({tag, ".resp_one_cycle"}, resp_o, 1'b0);
    check({tag, ".idle_req"}, {write_o, read_o}, 2'b00);
  endtask

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [15:0]  pat;
    int           pat_len;
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] a;
    bit w;
    vecs[0] = '{1'b1, 1'b0, 32'h0000_1234,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                16'hFFFF, 16, 32'h0000_1220};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_2040,
                {64'hDEAD_0004_0004_BEEF, 64'hDEAD_0003_0003_BEEF,
                 64'hDEAD_0002_0002_BEEF, 64'hDEAD_0001_0001_BEEF},
                16'h004D, 7, 32'h0000_2040};
    vecs[2] = '{1'b1, 1'b0, 32'hFFFF_FFFF,
                {64'hA4A4_A4A4_0000_0004, 64'hA3A3_A3A3_0000_0003,
                 64'hA2A2_A2A2_0000_0002, 64'hA1A1_A1A1_0000_0001},
                16'h0069, 7, 32'hFFFF_FFE0};
    vecs[3] = '{1'b0, 1'b1, 32'h8000_001F,
                {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h5555_AAAA_5555_AAAA, 64'hAAAA_5555_AAAA_5555},
                16'hFFFF, 16, 32'h8000_0000};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0040,
                {64'hC4C4_C4C4_C4C4_C4C4, 64'hC3C3_C3C3_C3C3_C3C3,
                 64'hC2C2_C2C2_C2C2_C2C2, 64'hC1C1_C1C1_C1C1_C1C1},
                16'h0025, 6, 32'h0000_0040};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0047,
                {64'hB4B4_B4B4_B4B4_B4B4, 64'hB3B3_B3B3_B3B3_B3B3,
                 64'hB2B2_B2B2_B2B2_B2B2, 64'hB1B1_B1B1_B1B1_B1B1},
                16'hFFFF, 16, 32'h0000_0040};

    rst = 1'b1;
    line_i = '0;
    address_i = '0;
    read_i = 1'b0;
    write_i = 1'b0;
    burst_i = '0;
    resp_i = 1'b0;
    last_fill = '0;
    repeat (3) step();
    check("reset.req", {resp_o, write_o, read_o}, 3'b000);
    check("reset.addr", address_o, 32'h0);
    check("reset.burst", burst_o, 64'h0);
    check("reset.line", line_o, 256'h0);
    check("reset.err", error_o, 1'b0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].line,
              vecs[i].pat, vecs[i].pat_len, vecs[i].exp_addr);

    // resp_i while idle must not move anything
    resp_i = 1'b1;
    burst_i = 64'hFFFF_0000_FFFF_0000;
    repeat (3) begin
      step();
      check("idle_resp.req", {resp_o, write_o, read_o}, 3'b000);
      check("idle_resp.line", line_o, last_fill);
    end
    resp_i = 1'b0;

    // reset after two beats of a read abandons it
    read_i = 1'b1;
    address_i = 32'h0000_3000;
    step();
    resp_i = 1'b1;
    burst_i = 64'h7777_7777_7777_7777;
    step();
    step();
    resp_i = 1'b0;
    read_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_fill = '0;
    check("midrst.req", {resp_o, write_o, read_o}, 3'b000);
    check("midrst.addr", address_o, 32'h0);
    check("midrst.burst", burst_o, 64'h0);
    check("midrst.line", line_o, 256'h0);
    step();
    check("midrst.no_resp", {resp_o, read_o}, 2'b00);
    run_txn("after_rst", 1'b1, 1'b0, 32'h0000_3010, rand_line(), 16'h0, 0, 32'h0000_3000);

    for (int i = 0; i < 20; i++) begin
      a = $urandom();
      w = $urandom_range(0, 1);
      run_txn($sformatf("rand%0d", i), !w, w, a, rand_line(), 16'h0, 0, a - (a % 32));
    end

`ifdef CACHELINE_BURST_ADAPTER_TIMEOUT_EN
    read_i = 1'b1;
    address_i = 32'h0000_5000;
    step();
    read_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("wd.reading", {error_o, resp_o, read_o}, 3'b001);
      step();
    end
    check("wd.tripped", {error_o, resp_o, read_o}, 3'b100);
    repeat (3) step();
    check("wd.sticky", {error_o, resp_o, read_o}, 3'b100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("wd.cleared", error_o, 1'b0);
`else
    run_txn("long_stall", 1'b1, 1'b0, 32'h0000_5000, rand_line(), 16'h0, 16, 32'h0000_5000);
    check("no_wd.err", error_o, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
